red_bbox_tracker: RTL and testbench
===================================

# red_bbox_tracker

Inline stage between `ov7670_capture` and `frame_buffer` on the camera write path. It forwards every captured RGB444 pixel to the buffer one cycle later, optionally replaced by a binary red mask. In parallel it accumulates per-frame statistics of "red" pixels (count and bounding box) and publishes them at end of frame. Downstream consumers (LED/overlay logic in the VGA path) read the latched results.

## Interface
Parameters:
- `c_img_cols`, 320: pixels per line.
- `c_img_rows`, 240: lines per frame.
- `c_nb_img_pxls`, 17: address width (log2 of cols*rows, rounded up).
- `c_nb_buf`, 12: pixel width, RGB444 as {r[11:8], g[7:4], b[3:0]}.
- `c_r_min`, 4'd8: minimum red value for a match.
- `c_margin`, 4'd3: red must exceed green and blue by more than this.

Ports:
- `clk`  in  1  system clock (100 MHz domain). One clock; reset is synchronous and active-low.
- `rst`  in  1  synchronous active-low reset.
- `rgbmode`  in  1  1 = RGB444 stream, 0 = YUV (no classification).
- `show_mask`  in  1  1 = forward mask pixels instead of camera pixels.
- `in_we`  in  1  write strobe from capture.
- `in_addr`  in  c_nb_img_pxls  write address from capture.
- `in_data`  in  c_nb_buf  pixel from capture.
- `out_we`  out  1  write strobe to frame buffer.
- `out_addr`  out  c_nb_img_pxls  address to frame buffer.
- `out_data`  out  c_nb_buf  pixel to frame buffer.
- `frame_done`  out  1  one-cycle pulse when results update.
- `bbox_valid`  out  1  last published frame had at least one match.
- `xmin`, `xmax`  out  9  bounding-box columns.
- `ymin`, `ymax`  out  8  bounding-box rows.
- `red_count`  out  c_nb_img_pxls  number of matching pixels.

## Operation
- Match, evaluated only when `rgbmode`=1: r >= c_r_min, and r > g + c_margin, and r > b + c_margin. Sums are computed 5 bits wide, with no wrap.
- Write path: `out_we`/`out_addr` are `in_we`/`in_addr` registered. `out_data` = `show_mask` & `rgbmode` ? (match ? 12'hFFF : 12'h000) : `in_data`.
- Position tracking uses an expected-address counter `exp_addr` and column/row counters `col`/`row`.
  - A write with `in_addr`=0 starts a frame: `col`=0, `row`=0, `frame_ok`=1, working stats initialised, pixel 0 included.
  - Otherwise, on each write `col` increments; when it reaches c_img_cols-1 it wraps to 0 and `row` increments.
- Frame corruption: a write with `in_addr` ≠ `exp_addr` (and ≠ 0) clears `frame_ok`. Accumulation continues but the frame is not published.
- Working stats on a match:
  - `count`++.
  - `xmin`=min(`xmin`,col), `xmax`=max(`xmax`,col).
  - `ymin`=min(`ymin`,row), `ymax`=max(`ymax`,row).
  - Init values: `xmin`=c_img_cols-1, `ymin`=c_img_rows-1, `xmax`=`ymax`=0, `count`=0.
- End of frame is a write to `in_addr` = c_img_pxls-1. If `frame_ok`, results are published. If `rgbmode` was 0 on any write of the frame, `frame_ok` was cleared and nothing is published.
- Publish, including the last pixel's contribution:
  - `bbox_valid` = (`count` ≠ 0).
  - When `bbox_valid`=0, box outputs are forced to 0.
  - `red_count` = `count`.
- Writes arriving before the first address-0 write after reset are forwarded but not accumulated.

## Timing
- Write-path latency: exactly 1 cycle, with no gaps or reordering. `out_we` is never asserted without a corresponding `in_we`.
- Stats update in the cycle after the write that carries the pixel.
- Result outputs and `frame_done` change in the cycle after the end-of-frame write; `frame_done` is high for exactly 1 cycle.
- Results hold until the next successful publish.
- Reset values (rst=0 at a clock edge): `out_we`=0, `out_addr`=0, `out_data`=0, `frame_done`=0, `bbox_valid`=0, `xmin`=`xmax`=`ymin`=`ymax`=0, `red_count`=0, `frame_ok`=0, `synced`=0.
- Reset mid-frame discards all partial stats.
- Simultaneous events: an end-of-frame write that is also a match contributes to the published result. An address-0 write immediately after end of frame starts the next frame with no dead cycle.

## Structure
- Shared package `ov7670_pkg`: image size constants, c_nb_buf, RGB444 field slice positions, mask colour constants.
- Sub-module `red_classifier`: combinational match from a 12-bit pixel, parameterised by c_r_min and c_margin. Reused later by the display overlay.
- Top module: write-path register, position counters, working stats, result registers.

## Test plan
- Full 320x240 frame with a red square (12'hF00) at cols 100..139, rows 50..69 on black → `frame_done` 1 pulse; `bbox_valid`=1; `xmin`=100, `xmax`=139, `ymin`=50, `ymax`=69, `red_count`=800.
- All-gray frame (12'h888) → `bbox_valid`=0, all box outputs 0, `red_count`=0.
- Single red pixel at the last address (col 319, row 239) → `xmin`=`xmax`=319, `ymin`=`ymax`=239, `red_count`=1.
- Frame with an address jump (skip addr 1000) → no `frame_done`, previous results held. The next clean frame publishes normally.
- `show_mask`=1, pixels 12'hF00 / 12'h0F0 / 12'h900 (r=9,g=0,b=0) / 12'h744 → `out_data` FFF / 000 / FFF / 000, each 1 cycle after input. With `rgbmode`=0, data is passed unchanged and nothing is published.
- Assert `rst`=0 mid-frame for 1 cycle → all outputs 0 next cycle. The frame in progress is not published.

Source files
------------

// File: rtl/ov7670_pkg.sv
// Shared camera-path constants: image geometry, pixel layout and mask colours.
// Used by the capture-side tracker and by the display overlay.
package ov7670_pkg;

  localparam int c_cam_cols    = 320;
  localparam int c_cam_rows    = 240;
  localparam int c_cam_nb_addr = 17;
  localparam int c_cam_nb_buf  = 12;

  // RGB444 packing: {r, g, b}
  localparam int c_r_msb = 11;
  localparam int c_r_lsb = 8;
  localparam int c_g_msb = 7;
  localparam int c_g_lsb = 4;
  localparam int c_b_msb = 3;
  localparam int c_b_lsb = 0;

  localparam logic [11:0] c_mask_on  = 12'hFFF;
  localparam logic [11:0] c_mask_off = 12'h000;

  typedef logic [3:0] chan_t;

endpackage

// File: rtl/red_classifier.sv
// Combinational "is this pixel red" test on an RGB444 pixel.
// Sums are widened to 5 bits so a large margin never wraps.
module red_classifier
  import ov7670_pkg::*;
#(
  parameter logic [3:0] c_r_min  = 4'd8,
  parameter logic [3:0] c_margin = 4'd3
) (
  input  logic [c_cam_nb_buf-1:0] pixel,
  output logic                    match
);

  chan_t      r, g, b;
  logic [4:0] g_lim, b_lim;

  assign r     = pixel[c_r_msb:c_r_lsb];
  assign g     = pixel[c_g_msb:c_g_lsb];
  assign b     = pixel[c_b_msb:c_b_lsb];
  assign g_lim = {1'b0, g} + {1'b0, c_margin};
  assign b_lim = {1'b0, b} + {1'b0, c_margin};

  assign match = (r >= c_r_min) && ({1'b0, r} > g_lim) && ({1'b0, r} > b_lim);

endmodule

// File: rtl/red_bbox_tracker.sv
// Camera write-path stage: forwards pixels (optionally as a red mask) with one
// cycle of latency and publishes per-frame red-pixel count and bounding box.
module red_bbox_tracker
  import ov7670_pkg::*;
#(
  parameter int         c_img_cols    = c_cam_cols,
  parameter int         c_img_rows    = c_cam_rows,
  parameter int         c_nb_img_pxls = c_cam_nb_addr,
  parameter int         c_nb_buf      = c_cam_nb_buf,
  parameter logic [3:0] c_r_min       = 4'd8,
  parameter logic [3:0] c_margin      = 4'd3
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     rgbmode,
  input  logic                     show_mask,
  input  logic                     in_we,
  input  logic [c_nb_img_pxls-1:0] in_addr,
  input  logic [c_nb_buf-1:0]      in_data,
  output logic                     out_we,
  output logic [c_nb_img_pxls-1:0] out_addr,
  output logic [c_nb_buf-1:0]      out_data,
  output logic                     frame_done,
  output logic                     bbox_valid,
  output logic [8:0]               xmin,
  output logic [8:0]               xmax,
  output logic [7:0]               ymin,
  output logic [7:0]               ymax,
  output logic [c_nb_img_pxls-1:0] red_count
);

  localparam logic [c_nb_img_pxls-1:0] c_last_addr = c_nb_img_pxls'(c_img_cols * c_img_rows - 1);
  localparam logic [8:0]               c_last_col  = 9'(c_img_cols - 1);
  localparam logic [7:0]               c_last_row  = 8'(c_img_rows - 1);

  logic pix_match;

  red_classifier #(
    .c_r_min  (c_r_min),
    .c_margin (c_margin)
  ) u_classifier (
    .pixel (in_data),
    .match (pix_match)
  );

  logic                     out_we_q, out_we_d;
  logic [c_nb_img_pxls-1:0] out_addr_q, out_addr_d;
  logic [c_nb_buf-1:0]      out_data_q, out_data_d;
  logic                     frame_done_q, frame_done_d;
  logic                     bbox_valid_q, bbox_valid_d;
  logic [8:0]               xmin_q, xmin_d, xmax_q, xmax_d;
  logic [7:0]               ymin_q, ymin_d, ymax_q, ymax_d;
  logic [c_nb_img_pxls-1:0] red_count_q, red_count_d;

  logic                     synced_q, synced_d;
  logic                     frame_ok_q, frame_ok_d;
  logic [c_nb_img_pxls-1:0] exp_addr_q, exp_addr_d;
  logic [8:0]               col_q, col_d;
  logic [7:0]               row_q, row_d;
  logic [8:0]               w_xmin_q, w_xmin_d, w_xmax_q, w_xmax_d;
  logic [7:0]               w_ymin_q, w_ymin_d, w_ymax_q, w_ymax_d;
  logic [c_nb_img_pxls-1:0] w_count_q, w_count_d;

  logic frame_start;

  always_comb begin
    frame_start  = in_we && (in_addr == '0);

    out_we_d     = in_we;
    out_addr_d   = in_addr;
    out_data_d   = (show_mask && rgbmode) ? (pix_match ? c_mask_on : c_mask_off) : in_data;

    frame_done_d = 1'b0;
    bbox_valid_d = bbox_valid_q;
    xmin_d       = xmin_q;
    xmax_d       = xmax_q;
    ymin_d       = ymin_q;
    ymax_d       = ymax_q;
    red_count_d  = red_count_q;

    synced_d     = synced_q;
    frame_ok_d   = frame_ok_q;
    exp_addr_d   = exp_addr_q;
    col_d        = col_q;
    row_d        = row_q;
    w_xmin_d     = w_xmin_q;
    w_xmax_d     = w_xmax_q;
    w_ymin_d     = w_ymin_q;
    w_ymax_d     = w_ymax_q;
    w_count_d    = w_count_q;

    // Until the first address-0 write we do not know where we are in the frame.
    if (in_we && (frame_start || synced_q)) begin
      synced_d   = 1'b1;
      exp_addr_d = in_addr + c_nb_img_pxls'(1);

      if (frame_start) begin
        col_d      = '0;
        row_d      = '0;
        frame_ok_d = rgbmode;
        w_xmin_d   = c_last_col;
        w_xmax_d   = '0;
        w_ymin_d   = c_last_row;
        w_ymax_d   = '0;
        w_count_d  = '0;
      end else begin
        if (col_q == c_last_col) begin
          col_d = '0;
          row_d = row_q + 8'd1;
        end else begin
          col_d = col_q + 9'd1;
        end
        frame_ok_d = frame_ok_q && rgbmode && (in_addr == exp_addr_q);
      end

      if (rgbmode && pix_match) begin
        w_count_d = w_count_d + c_nb_img_pxls'(1);
        if (col_d < w_xmin_d) w_xmin_d = col_d;
        if (col_d > w_xmax_d) w_xmax_d = col_d;
        if (row_d < w_ymin_d) w_ymin_d = row_d;
        if (row_d > w_ymax_d) w_ymax_d = row_d;
      end

      // Publish from the updated working set so the last pixel counts.
      if ((in_addr == c_last_addr) && frame_ok_d) begin
        frame_done_d = 1'b1;
        bbox_valid_d = (w_count_d != '0);
        xmin_d       = bbox_valid_d ? w_xmin_d : '0;
        xmax_d       = bbox_valid_d ? w_xmax_d : '0;
        ymin_d       = bbox_valid_d ? w_ymin_d : '0;
        ymax_d       = bbox_valid_d ? w_ymax_d : '0;
        red_count_d  = w_count_d;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      out_we_q     <= 1'b0;
      out_addr_q   <= '0;
      out_data_q   <= '0;
      frame_done_q <= 1'b0;
      bbox_valid_q <= 1'b0;
      xmin_q       <= '0;
      xmax_q       <= '0;
      ymin_q       <= '0;
      ymax_q       <= '0;
      red_count_q  <= '0;
      synced_q     <= 1'b0;
      frame_ok_q   <= 1'b0;
      exp_addr_q   <= '0;
      col_q        <= '0;
      row_q        <= '0;
      w_xmin_q     <= '0;
      w_xmax_q     <= '0;
      w_ymin_q     <= '0;
      w_ymax_q     <= '0;
      w_count_q    <= '0;
    end else begin
      out_we_q     <= out_we_d;
      out_addr_q   <= out_addr_d;
      out_data_q   <= out_data_d;
      frame_done_q <= frame_done_d;
      bbox_valid_q <= bbox_valid_d;
      xmin_q       <= xmin_d;
      xmax_q       <= xmax_d;
      ymin_q       <= ymin_d;
      ymax_q       <= ymax_d;
      red_count_q  <= red_count_d;
      synced_q     <= synced_d;
      frame_ok_q   <= frame_ok_d;
      exp_addr_q   <= exp_addr_d;
      col_q        <= col_d;
      row_q        <= row_d;
      w_xmin_q     <= w_xmin_d;
      w_xmax_q     <= w_xmax_d;
      w_ymin_q     <= w_ymin_d;
      w_ymax_q     <= w_ymax_d;
      w_count_q    <= w_count_d;
    end
  end

  assign out_we     = out_we_q;
  assign out_addr   = out_addr_q;
  assign out_data   = out_data_q;
  assign frame_done = frame_done_q;
  assign bbox_valid = bbox_valid_q;
  assign xmin       = xmin_q;
  assign xmax       = xmax_q;
  assign ymin       = ymin_q;
  assign ymax       = ymax_q;
  assign red_count  = red_count_q;

endmodule

// File: tb/tb_red_bbox_tracker.sv
// Bench for red_bbox_tracker on a reduced 32x24 image: directed frames plus
// randomized frames checked against a frame-level reference model.
module tb_red_bbox_tracker;

  localparam int COLS = 32;
  localparam int ROWS = 24;
  localparam int AW   = 10;
  localparam int NPIX = COLS * ROWS;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic          rgbmode = 1'b1;
  logic          show_mask = 1'b0;
  logic          in_we = 1'b0;
  logic [AW-1:0] in_addr = '0;
  logic [11:0]   in_data = '0;
  logic          out_we;
  logic [AW-1:0] out_addr;
  logic [11:0]   out_data;
  logic          frame_done;
  logic          bbox_valid;
  logic [8:0]    xmin, xmax;
  logic [7:0]    ymin, ymax;
  logic [AW-1:0] red_count;

  red_bbox_tracker #(
    .c_img_cols    (COLS),
    .c_img_rows    (ROWS),
    .c_nb_img_pxls (AW),
    .c_nb_buf      (12),
    .c_r_min       (4'd8),
    .c_margin      (4'd3)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .rgbmode    (rgbmode),
    .show_mask  (show_mask),
    .in_we      (in_we),
    .in_addr    (in_addr),
    .in_data    (in_data),
    .out_we     (out_we),
    .out_addr   (out_addr),
    .out_data   (out_data),
    .frame_done (frame_done),
    .bbox_valid (bbox_valid),
    .xmin       (xmin),
    .xmax       (xmax),
    .ymin       (ymin),
    .ymax       (ymax),
    .red_count  (red_count)
  );

  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  // Reference model state
  logic [11:0] fb [NPIX];
  bit  m_synced, m_ok, m_done;
  int  m_exp, m_widx;
  int  m_hits[$];
  int  e_valid, e_xmin, e_xmax, e_ymin, e_ymax, e_count;

  function automatic bit is_red(input logic [11:0] p);
    int r, g, b;
    r = int'(p[11:8]);
    g = int'(p[7:4]);
    b = int'(p[3:0]);
    return (r >= 8) && (r > g + 3) && (r > b + 3);
  endfunction

  task automatic publish();
    e_count = m_hits.size();
    e_valid = (e_count != 0);
    e_xmin = 0; e_xmax = 0; e_ymin = 0; e_ymax = 0;
    if (e_valid) begin
      e_xmin = COLS; e_ymin = ROWS; e_xmax = -1; e_ymax = -1;
      foreach (m_hits[k]) begin
        int c, r;
        c = m_hits[k] % COLS;
        r = m_hits[k] / COLS;
        if (c < e_xmin) e_xmin = c;
        if (c > e_xmax) e_xmax = c;
        if (r < e_ymin) e_ymin = r;
        if (r > e_ymax) e_ymax = r;
      end
    end
    m_done = 1'b1;
  endtask

  task automatic model_write(input int addr, input logic [11:0] data);
    if (addr == 0) begin
      m_synced = 1'b1;
      m_ok     = rgbmode;
      m_widx   = 0;
      m_hits.delete();
    end else if (m_synced) begin
      m_widx++;
      if (addr != m_exp || !rgbmode) m_ok = 1'b0;
    end
    if (m_synced) begin
      m_exp = addr + 1;
      if (rgbmode && is_red(data)) m_hits.push_back(m_widx);
      if (addr == NPIX - 1 && m_ok) publish();
    end
  endtask

  task automatic check_results(input string pfx);
    check({pfx, "_valid"}, 32'(bbox_valid), e_valid);
    check({pfx, "_xmin"},  32'(xmin),       e_xmin);
    check({pfx, "_xmax"},  32'(xmax),       e_xmax);
    check({pfx, "_ymin"},  32'(ymin),       e_ymin);
    check({pfx, "_ymax"},  32'(ymax),       e_ymax);
    check({pfx, "_count"}, 32'(red_count),  e_count);
  endtask

  // Called on a falling edge; returns on the next falling edge after checking.
  task automatic put(input bit we, input int addr, input logic [11:0] data);
    logic [11:0] exp_data;
    in_we   = we;
    in_addr = AW'(addr);
    in_data = data;
    exp_data = (show_mask && rgbmode) ? (is_red(data) ? 12'hFFF : 12'h000) : data;
    m_done = 1'b0;
    if (we) model_write(addr, data);
    @(negedge clk);
    check("wpath", 32'({out_we, out_addr, out_data}), 32'({we, AW'(addr), exp_data}));
    check("frame_done", 32'(frame_done), 32'(m_done));
    if (m_done) check_results("pub");
  endtask

  task automatic pulse_reset();
    rst   = 1'b0;
    in_we = 1'b0;
    @(negedge clk);
    m_synced = 1'b0; m_ok = 1'b0;
    e_valid = 0; e_xmin = 0; e_xmax = 0; e_ymin = 0; e_ymax = 0; e_count = 0;
    check("rst_wpath", 32'({out_we, out_addr, out_data}), 32'd0);
    check("rst_done",  32'(frame_done), 32'd0);
    check_results("rst");
    rst = 1'b1;
  endtask

  task automatic fill_rect(input logic [11:0] bg, input logic [11:0] fg,
                           input int c0, input int c1, input int r0, input int r1);
    for (int a = 0; a < NPIX; a++)
      fb[a] = ((a % COLS) >= c0 && (a % COLS) <= c1 && (a / COLS) >= r0 && (a / COLS) <= r1) ? fg : bg;
  endtask

  task automatic fill_random();
    int c0, c1, r0, r1;
    bit use_rect;
    c0 = $urandom_range(0, COLS - 1); c1 = $urandom_range(c0, COLS - 1);
    r0 = $urandom_range(0, ROWS - 1); r1 = $urandom_range(r0, ROWS - 1);
    use_rect = ($urandom_range(0, 3) != 0);
    for (int a = 0; a < NPIX; a++) begin
      if (use_rect && (a % COLS) >= c0 && (a % COLS) <= c1 && (a / COLS) >= r0 && (a / COLS) <= r1)
        fb[a] = 12'h800 | 12'($urandom_range(0, 12'h7FF));
      else
        fb[a] = 12'($urandom_range(0, 12'h7FF));
    end
  endtask

  // skip: address left out (-1 none); yuv_at: address written with rgbmode=0 (-1 none, -2 all)
  task automatic run_frame(input int skip, input int yuv_at, input bit gaps);
    for (int a = 0; a < NPIX; a++) begin
      if (a == skip) continue;
      if (gaps && $urandom_range(0, 7) == 0) put(1'b0, a, fb[a]);
      rgbmode = !(yuv_at == -2 || yuv_at == a);
      put(1'b1, a, fb[a]);
    end
    rgbmode = 1'b1;
    check_results("held");
  endtask

  initial begin
    logic [11:0] mask_in  [4];
    logic [11:0] mask_out [4];
    mask_in  = '{12'hF00, 12'h0F0, 12'h900, 12'h744};
    mask_out = '{12'hFFF, 12'h000, 12'hFFF, 12'h000};

    e_valid = 0; e_xmin = 0; e_xmax = 0; e_ymin = 0; e_ymax = 0; e_count = 0;
    m_synced = 1'b0; m_ok = 1'b0; m_done = 1'b0; m_exp = 0; m_widx = 0;

    @(negedge clk);
    pulse_reset();

    // Writes before any address-0 write are forwarded only
    for (int a = 5; a < 10; a++) put(1'b1, a, 12'hF00);

    fill_rect(12'h000, 12'hF00, 10, 19, 5, 9);
    run_frame(-1, -1, 1'b0);
    check("sq_count", 32'(red_count), 32'd50);
    check("sq_box", 32'({xmin, xmax, ymin, ymax}), 32'({9'd10, 9'd19, 8'd5, 8'd9}));

    fill_rect(12'h888, 12'h888, 0, 0, 0, 0);
    run_frame(-1, -1, 1'b1);
    check("gray_valid", 32'(bbox_valid), 32'd0);

    fill_rect(12'h000, 12'hF00, COLS - 1, COLS - 1, ROWS - 1, ROWS - 1);
    run_frame(-1, -1, 1'b0);
    check("last_box", 32'({xmin, xmax, ymin, ymax}), 32'({9'd31, 9'd31, 8'd23, 8'd23}));
    check("last_count", 32'(red_count), 32'd1);

    fill_rect(12'h000, 12'hF00, 0, 3, 0, 3);
    run_frame(100, -1, 1'b0);
    check("jump_held", 32'(red_count), 32'd1);
    run_frame(-1, -1, 1'b0);
    check("clean_count", 32'(red_count), 32'd16);

    show_mask = 1'b1;
    for (int i = 0; i < 4; i++) begin
      put(1'b1, 200 + i, mask_in[i]);
      check("mask_px", 32'(out_data), 32'(mask_out[i]));
    end
    fill_rect(12'h000, 12'hF00, 2, 6, 2, 6);
    run_frame(-1, -2, 1'b0);
    check("yuv_held", 32'(red_count), 32'd16);
    show_mask = 1'b0;

    // Reset partway through a frame, then finish it unsynced
    for (int a = 0; a < 300; a++) put(1'b1, a, fb[a]);
    pulse_reset();
    for (int a = 300; a < NPIX; a++) put(1'b1, a, fb[a]);
    check_results("midrst");

    for (int f = 0; f < 12; f++) begin
      fill_random();
      show_mask = $urandom_range(0, 1);
      run_frame(($urandom_range(0, 3) == 0) ? $urandom_range(1, NPIX - 2) : -1,
                ($urandom_range(0, 5) == 0) ? $urandom_range(0, NPIX - 1) : -1,
                $urandom_range(0, 1));
    end

    in_we = 1'b0;
    @(negedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
